// File: rtl/psk_mod_core.sv
// psk_mod_core: BPSK/QPSK baseband-to-DAC sample engine.
//
// Each accepted carrier strobe (sample_en & enable) produces one DAC word.
// Every SPS accepted strobes a new symbol is loaded. Its bits come either
// from an internal repeating pattern (LSB first) or from ext_data. The
// carrier is multiplied by +/-1 per symbol bit, shifted up by GAIN_SHIFT,
// optionally summed with shifted noise, clamped to OW bits and emitted as
// an offset-binary word through a one-entry valid/ready output slot.
//
// Ports:
//   clk, n_reset          clock, synchronous active-low reset
//   enable, sample_en     strobe qualification
//   mode, ext_sel         0/1 = BPSK/QPSK, internal/external bits (sampled at boundaries)
//   ext_data[1:0]         external symbol bits {I,Q}
//   carrier_i/q [SW]      signed carrier samples
//   noise [NW], noise_en  signed noise sample and its enable
//   dac_rdy               serializer ready
//   dac_word [OW], dac_valid   output slot
//   sym_strobe, data_bits symbol boundary pulse and current bits
//   drop                  pulse when a finished sample meets a full, stalled slot
//   sat                   sticky clamp indicator
module psk_mod_core #(
    parameter int                 SW          = 8,
    parameter int                 NW          = 12,
    parameter int                 OW          = 12,
    parameter int                 PAT_LEN     = 8,
    parameter logic [PAT_LEN-1:0] PAT         = 8'b10010100,
    parameter int                 SPS         = 20,
    parameter int                 GAIN_SHIFT  = 4,
    parameter int                 NOISE_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 noise_en,
    input  logic                 ext_sel,
    input  logic [1:0]           ext_data,
    input  logic                 sample_en,
    input  logic signed [SW-1:0] carrier_i,
    input  logic signed [SW-1:0] carrier_q,
    input  logic signed [NW-1:0] noise,
    input  logic                 dac_rdy,
    output logic [OW-1:0]        dac_word,
    output logic                 dac_valid,
    output logic                 sym_strobe,
    output logic [1:0]           data_bits,
    output logic                 drop,
    output logic                 sat
);
    localparam int PW   = $clog2(PAT_LEN);
    localparam int CW   = (SPS > 1) ? $clog2(SPS) : 1;
    // Two extra bits so that +/-ci +/-cq with both at the negative extreme is exact.
    localparam int MW   = SW + 2;
    localparam int GW   = MW + GAIN_SHIFT;
    localparam int SUMW = ((GW > NW) ? GW : NW) + 1;
    localparam logic signed [SUMW-1:0] MAX_S = SUMW'((2 ** (OW - 1)) - 1);
    localparam logic signed [SUMW-1:0] MIN_S = -MAX_S - SUMW'(1);

    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          ptr_q, ptr_d, ptr_p1, ptr_p2;
    logic [1:0]             bits_q, bits_d;
    logic                   mode_q, mode_d;
    logic                   sym_q, sym_d;
    logic                   s1_valid_q, s1_valid_d;
    logic signed [SUMW-1:0] s1_sum_q, s1_sum_d;
    logic [OW-1:0]          word_q, word_d;
    logic                   valid_q, valid_d;
    logic                   drop_q, drop_d;
    logic                   sat_q, sat_d;

    logic                   strobe, boundary, i_pos, load, clamp;
    logic signed [MW-1:0]   ci_x, cq_x, term_i, term_q, m_val;
    logic signed [NW-1:0]   noise_sh;
    logic [OW-1:0]          clamped;

    assign strobe   = sample_en & enable;
    assign boundary = strobe && (count_q == CW'(SPS - 1));

    // Symbol sequencing: counter, pattern pointer, bit and mode capture.
    always_comb begin
        count_d = count_q;
        ptr_d   = ptr_q;
        bits_d  = bits_q;
        mode_d  = mode_q;
        sym_d   = 1'b0;
        ptr_p1  = (ptr_q  == PW'(PAT_LEN - 1)) ? '0 : ptr_q  + 1'b1;
        ptr_p2  = (ptr_p1 == PW'(PAT_LEN - 1)) ? '0 : ptr_p1 + 1'b1;
        if (boundary) begin
            count_d = '0;
            sym_d   = 1'b1;
            mode_d  = mode;
            if (ext_sel) begin
                bits_d = ext_data;
            end else if (mode) begin
                bits_d = {PAT[ptr_p1], PAT[ptr_q]};
                ptr_d  = ptr_p2;
            end else begin
                bits_d = {1'b0, PAT[ptr_q]};
                ptr_d  = ptr_p1;
            end
        end else if (strobe) begin
            count_d = count_q + 1'b1;
        end
    end

    // Mixing uses the _d bits/mode so a boundary sample sees its new symbol.
    always_comb begin
        ci_x       = MW'(carrier_i);
        cq_x       = MW'(carrier_q);
        i_pos      = mode_d ? bits_d[1] : bits_d[0];
        term_i     = i_pos ? ci_x : -ci_x;
        term_q     = mode_d ? (bits_d[0] ? cq_x : -cq_x) : '0;
        m_val      = term_i + term_q;
        noise_sh   = noise >>> NOISE_SHIFT;
        s1_sum_d   = (SUMW'(m_val) <<< GAIN_SHIFT)
                   + (noise_en ? SUMW'(noise_sh) : '0);
        s1_valid_d = strobe;
    end

    // Clamp, offset-binary format and the one-entry output slot.
    always_comb begin
        clamp = 1'b0;
        if (s1_sum_q > MAX_S) begin
            clamped = {1'b0, {(OW-1){1'b1}}};
            clamp   = 1'b1;
        end else if (s1_sum_q < MIN_S) begin
            clamped = {1'b1, {(OW-1){1'b0}}};
            clamp   = 1'b1;
        end else begin
            clamped = s1_sum_q[OW-1:0];
        end
        load    = s1_valid_q && (!valid_q || dac_rdy);
        drop_d  = s1_valid_q && !load;
        sat_d   = sat_q | (s1_valid_q & clamp);
        word_d  = word_q;
        valid_d = valid_q;
        if (load) begin
            word_d  = {~clamped[OW-1], clamped[OW-2:0]};
            valid_d = 1'b1;
        end else if (dac_rdy) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count_q    <= CW'(SPS - 1);
            ptr_q      <= '0;
            bits_q     <= '0;
            mode_q     <= 1'b0;
            sym_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            word_q     <= {1'b1, {(OW-1){1'b0}}};
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            bits_q     <= bits_d;
            mode_q     <= mode_d;
            sym_q      <= sym_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            sat_q      <= sat_d;
        end
    end

    assign dac_word   = word_q;
    assign dac_valid  = valid_q;
    assign sym_strobe = sym_q;
    assign data_bits  = bits_q;
    assign drop       = drop_q;
    assign sat        = sat_q;
endmodule
